// File: rtl/btn_evt_pkg.sv
// Shared event encoding for the button event scheduler.
package btn_evt_pkg;
    localparam int EV_W = 2;
    localparam logic [EV_W-1:0] EV_PRESS   = 2'b00;
    localparam logic [EV_W-1:0] EV_RELEASE = 2'b01;
    localparam logic [EV_W-1:0] EV_LONG    = 2'b10;
endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: synchroniser, tick-based debounce and long-press detection.
// Raise pulses are combinational so the scheduler latches them on the same edge pb_state moves.
module button_debounce_ch #(
    parameter int STABLE_TICKS = 16,
    parameter int LONG_TICKS   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    input  logic tick,
    output logic pb_state,
    output logic raise_press,
    output logic raise_release,
    output logic raise_long
);
    localparam int SW = $clog2(STABLE_TICKS) + 1;
    localparam int HW = $clog2(LONG_TICKS) + 1;
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_TICKS - 1);

    logic          sync0;
    logic          sync1;
    logic          long_done;
    logic          toggle;
    logic [SW-1:0] stable_cnt;
    logic [HW-1:0] hold_cnt;

    assign toggle        = tick && (sync1 != pb_state) && (stable_cnt == STABLE_LAST);
    assign raise_press   = toggle && !pb_state;
    assign raise_release = toggle && pb_state;
    assign raise_long    = tick && pb_state && !long_done && (hold_cnt == LONG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            pb_state   <= 1'b0;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            long_done  <= 1'b0;
        end else begin
            sync0 <= ~pb;
            sync1 <= sync0;
            if (tick) begin
                if (sync1 == pb_state) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == STABLE_LAST) begin
                    pb_state   <= ~pb_state;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
                // Uses the pre-toggle state, so the press tick itself never counts as held.
                if (!pb_state) begin
                    hold_cnt  <= '0;
                    long_done <= 1'b0;
                end else if (!long_done) begin
                    if (hold_cnt == LONG_LAST) begin
                        long_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/button_event_scheduler.sv
// Debounced buttons feeding a round-robin arbiter and a small event FIFO.
// Output handshake: an event transfers on every clk edge where ev_valid && ev_ready; ev_btn/ev_type hold while ev_valid && !ev_ready.
module button_event_scheduler
    import btn_evt_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 16,
    parameter int LONG_TICKS   = 1000,
    parameter int FIFO_DEPTH   = 4,
    localparam int BTN_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pb,
    output logic [N_BTN-1:0] pb_state,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [BTN_W-1:0] ev_btn,
    output logic [EV_W-1:0]  ev_type,
    output logic             ev_drop
);
    localparam int TW = $clog2(TICK_DIV) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = BTN_W + 1;
    localparam int EW = BTN_W + EV_W;

    logic [TW-1:0]    div_cnt;
    logic             tick;
    logic [N_BTN-1:0] raise_press, raise_release, raise_long;
    logic [N_BTN-1:0] pend_press, pend_long, pend_release;
    logic [N_BTN-1:0] gnt_press, gnt_long, gnt_release;
    logic [BTN_W-1:0] rr_ptr, gnt_idx;
    logic [CW-1:0]    cand, rr_next;
    logic [EV_W-1:0]  gnt_type;
    logic             found, grant, pop, full, empty;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [EW-1:0]    head;

    assign tick = (div_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .STABLE_TICKS(STABLE_TICKS),
            .LONG_TICKS  (LONG_TICKS)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .pb           (pb[i]),
            .tick         (tick),
            .pb_state     (pb_state[i]),
            .raise_press  (raise_press[i]),
            .raise_release(raise_release[i]),
            .raise_long   (raise_long[i])
        );
    end

    // Round-robin scan: first button at or after rr_ptr with anything pending.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cand = {1'b0, rr_ptr} + CW'(i);
            if (cand >= CW'(N_BTN)) cand = cand - CW'(N_BTN);
            if (!found && (pend_press[cand[BTN_W-1:0]] || pend_long[cand[BTN_W-1:0]] ||
                           pend_release[cand[BTN_W-1:0]])) begin
                found   = 1'b1;
                gnt_idx = cand[BTN_W-1:0];
            end
        end
        rr_next = {1'b0, gnt_idx} + 1'b1;
        if (rr_next == CW'(N_BTN)) rr_next = '0;
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && ev_ready;
    assign grant    = found && (!full || pop);
    assign ev_valid = !empty;
    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign ev_btn   = head[EW-1:EV_W];
    assign ev_type  = head[EV_W-1:0];

    // Press before long before release keeps each button's events in causal order.
    always_comb begin
        gnt_press   = '0;
        gnt_long    = '0;
        gnt_release = '0;
        if (pend_press[gnt_idx])     gnt_type = EV_PRESS;
        else if (pend_long[gnt_idx]) gnt_type = EV_LONG;
        else                         gnt_type = EV_RELEASE;
        if (grant) begin
            case (gnt_type)
                EV_PRESS: gnt_press[gnt_idx]   = 1'b1;
                EV_LONG:  gnt_long[gnt_idx]    = 1'b1;
                default:  gnt_release[gnt_idx] = 1'b1;
            endcase
        end
    end

    // A raise coinciding with a grant of the same bit re-arms it; only a raise onto a held bit drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_press   <= '0;
            pend_long    <= '0;
            pend_release <= '0;
            rr_ptr       <= '0;
            ev_drop      <= 1'b0;
        end else begin
            pend_press   <= (pend_press & ~gnt_press) | raise_press;
            pend_long    <= (pend_long & ~gnt_long) | raise_long;
            pend_release <= (pend_release & ~gnt_release) | raise_release;
            ev_drop      <= |((pend_press & ~gnt_press & raise_press) |
                              (pend_long & ~gnt_long & raise_long) |
                              (pend_release & ~gnt_release & raise_release));
            if (grant) rr_ptr <= rr_next[BTN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (grant) begin
                fifo_mem[wr_ptr[AW-1:0]] <= {gnt_idx, gnt_type};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed scenarios plus a random soak, all checked each cycle
// against an event-level model; literal expectations pin the model on the directed cases.
module tb_button_event_scheduler;
    localparam int N_BTN        = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int LONG_TICKS   = 8;
    localparam int FIFO_DEPTH   = 2;
    localparam int BTN_W        = 2;
    localparam int W            = BTN_W + 2;

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] pb;
    logic [N_BTN-1:0] pb_state;
    logic             ev_valid;
    logic             ev_ready;
    logic [BTN_W-1:0] ev_btn;
    logic [1:0]       ev_type;
    logic             ev_drop;

    button_event_scheduler #(
        .N_BTN       (N_BTN),
        .TICK_DIV    (TICK_DIV),
        .STABLE_TICKS(STABLE_TICKS),
        .LONG_TICKS  (LONG_TICKS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pb      (pb),
        .pb_state(pb_state),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_btn  (ev_btn),
        .ev_type (ev_type),
        .ev_drop (ev_drop)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_drop   = 0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] lit_q[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ev(input int b, input int t);
        ev = {b[BTN_W-1:0], t[1:0]};
    endfunction

    // ---------------- behavioural model ----------------
    // Event-level view: per button, a run length of disagreeing ticks and a count of held ticks;
    // pending events as a 3-slot set (press, long, release); the FIFO as a queue.
    int          m_pcnt;
    logic [N_BTN-1:0] m_s0, m_s1, m_state;
    int          m_run  [N_BTN];
    int          m_held [N_BTN];
    logic [2:0]  m_pend [N_BTN];
    logic [2:0]  m_raise[N_BTN];
    int          m_rr;
    logic        m_drop;
    logic        m_live = 1'b0;
    logic [W-1:0] exp_q[$];
    logic        m_tick, m_pop, m_found, m_gnt;
    int          m_gb, m_gbit, m_b;

    always @(posedge clk) begin
        if (rst) begin
            m_pcnt = 0; m_s0 = '0; m_s1 = '0; m_state = '0;
            for (int b = 0; b < N_BTN; b++) begin
                m_run[b] = 0; m_held[b] = 0; m_pend[b] = '0;
            end
            m_rr = 0; m_drop = 1'b0; exp_q.delete(); m_live = 1'b1;
        end else begin
            m_tick = (m_pcnt == TICK_DIV - 1);
            m_pcnt = (m_pcnt + 1) % TICK_DIV;
            for (int b = 0; b < N_BTN; b++) begin
                m_raise[b] = '0;
                if (m_tick) begin
                    if (m_state[b]) begin
                        m_held[b]++;
                        if (m_held[b] == LONG_TICKS) m_raise[b][1] = 1'b1;
                    end else begin
                        m_held[b] = 0;
                    end
                    if (m_s1[b] != m_state[b]) begin
                        m_run[b]++;
                        if (m_run[b] == STABLE_TICKS) begin
                            m_run[b] = 0;
                            if (m_state[b]) m_raise[b][2] = 1'b1;
                            else            m_raise[b][0] = 1'b1;
                            m_state[b] = ~m_state[b];
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                end
            end
            m_pop   = (exp_q.size() != 0) && ev_ready;
            m_found = 1'b0;
            m_gb    = 0;
            m_gbit  = 0;
            if (exp_q.size() < FIFO_DEPTH || m_pop) begin
                for (int k = 0; k < N_BTN; k++) begin
                    m_b = (m_rr + k) % N_BTN;
                    if (!m_found && m_pend[m_b] != 3'b000) begin
                        m_found = 1'b1;
                        m_gb    = m_b;
                        m_gbit  = m_pend[m_b][0] ? 0 : (m_pend[m_b][1] ? 1 : 2);
                    end
                end
            end
            m_drop = 1'b0;
            for (int b = 0; b < N_BTN; b++) begin
                for (int s = 0; s < 3; s++) begin
                    m_gnt = m_found && (m_gb == b) && (m_gbit == s);
                    if (m_raise[b][s] && m_pend[b][s] && !m_gnt) m_drop = 1'b1;
                    m_pend[b][s] = (m_pend[b][s] && !m_gnt) || m_raise[b][s];
                end
            end
            if (m_pop) void'(exp_q.pop_front());
            if (m_found) begin
                exp_q.push_back(ev(m_gb, (m_gbit == 0) ? 0 : ((m_gbit == 1) ? 2 : 1)));
                m_rr = (m_gb + 1) % N_BTN;
            end
            m_s1 = m_s0;
            m_s0 = ~pb;
        end
    end

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (m_live) begin
            cmp("pb_state", pb_state, m_state);
            cmp("ev_valid", ev_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) cmp("ev_head", {ev_btn, ev_type}, exp_q[0]);
            cmp("ev_drop", ev_drop, m_drop);
            if (ev_valid && ev_ready) got_q.push_back({ev_btn, ev_type});
            if (ev_drop) n_drop++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        pb = '1;
        ev_ready = 1'b1;
        repeat (80) step();
        got_q.delete();
        n_drop = 0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_mask(input logic [N_BTN-1:0] mask, input logic v);
        int n = 0;
        logic [N_BTN-1:0] want;
        want = v ? mask : '0;
        while ((pb_state & mask) !== want && n < 200) begin
            step();
            n++;
        end
        if ((pb_state & mask) !== want) cmp("wait_pb_state", pb_state & mask, want);
    endtask

    task automatic press_release(input logic [N_BTN-1:0] mask);
        pb = ~mask;
        wait_mask(mask, 1'b1);
        repeat (4) step();
        pb = '1;
        wait_mask(mask, 1'b0);
        repeat (6) step();
    endtask

    task automatic chk_log(input string name);
        cmp($sformatf("%s_count", name), got_q.size(), lit_q.size());
        for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
            cmp($sformatf("%s_ev%0d", name, i), got_q[i], lit_q[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int b;
        logic fnd;

        rst = 1'b1;
        pb = '1;
        ev_ready = 1'b1;
        repeat (3) step();
        cmp("rst_pb_state", pb_state, 0);
        cmp("rst_ev_valid", ev_valid, 0);
        cmp("rst_ev_btn", ev_btn, 0);
        cmp("rst_ev_type", ev_type, 0);
        cmp("rst_ev_drop", ev_drop, 0);
        rst = 1'b0;

        // Single press and release on button 0.
        settle();
        pb[0] = 1'b0;
        repeat (24) step();
        pb[0] = 1'b1;
        wait_mask(4'b0001, 1'b0);
        repeat (10) step();
        lit_q = '{ev(0, 0), ev(0, 1)};
        chk_log("s1");
        cmp("s1_drops", n_drop, 0);

        // Bounce on button 1 never settles.
        settle();
        for (int i = 0; i < 5; i++) begin
            pb[1] = 1'b0;
            repeat (3) step();
            pb[1] = 1'b1;
            repeat (3) step();
        end
        repeat (30) step();
        cmp("s2_state", pb_state[1], 0);
        cmp("s2_events", got_q.size(), 0);

        // Long press on button 2.
        settle();
        pb[2] = 1'b0;
        wait_mask(4'b0100, 1'b1);
        step();
        cmp("s3_press_head", {ev_valid, ev_btn, ev_type}, {1'b1, ev(2, 0)});
        n = 1;
        while (!(ev_valid && ev_type == 2'b10) && n < 100) begin
            step();
            n++;
        end
        cmp("s3_long_latency", n, 33);
        repeat (8) step();
        pb[2] = 1'b1;
        wait_mask(4'b0100, 1'b0);
        repeat (10) step();
        lit_q = '{ev(2, 0), ev(2, 2), ev(2, 1)};
        chk_log("s3");

        // Simultaneous presses and round-robin order.
        settle();
        pulse_reset();
        press_release(4'b1001);
        press_release(4'b0001);
        press_release(4'b1001);
        lit_q = '{ev(0, 0), ev(3, 0), ev(0, 1), ev(3, 1), ev(0, 0), ev(0, 1),
                  ev(3, 0), ev(0, 0), ev(3, 1), ev(0, 1)};
        chk_log("s4");

        // Back-pressure, pending overflow and drain.
        settle();
        ev_ready = 1'b0;
        pb = '0;
        wait_mask(4'b1111, 1'b1);
        repeat (4) step();
        pb = '1;
        wait_mask(4'b1111, 1'b0);
        repeat (4) step();
        cmp("s5_release_no_drop", n_drop, 0);
        fnd = 1'b0;
        b = 0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!fnd && m_pend[i][0]) begin
                fnd = 1'b1;
                b = i;
            end
        end
        cmp("s5_press_pending", fnd, 1);
        pb[b] = 1'b0;
        n = 0;
        while (n_drop == 0 && n < 100) begin
            step();
            n++;
        end
        cmp("s5_drop_seen", n_drop != 0, 1);
        ev_ready = 1'b1;
        repeat (6) step();
        pb[b] = 1'b1;
        wait_mask(4'b0001 << b, 1'b0);
        repeat (20) step();
        cmp("s5_drops", n_drop, 1);
        cmp("s5_event_count", got_q.size(), 9);
        cmp("s5_drained", ev_valid, 0);

        // Reset while events are queued.
        settle();
        ev_ready = 1'b0;
        pb[0] = 1'b0;
        n = 0;
        while (!ev_valid && n < 100) begin
            step();
            n++;
        end
        cmp("s6_queued", ev_valid, 1);
        repeat (2) step();
        got_q.delete();
        pulse_reset();
        cmp("s6_valid_after_rst", ev_valid, 0);
        cmp("s6_state_after_rst", pb_state, 0);
        n = 0;
        while (!pb_state[0] && n < 100) begin
            step();
            n++;
        end
        cmp("s6_repress_latency", n, 12);
        ev_ready = 1'b1;
        repeat (4) step();
        pb[0] = 1'b1;
        wait_mask(4'b0001, 1'b0);
        repeat (10) step();
        lit_q = '{ev(0, 0), ev(0, 1)};
        chk_log("s6");

        // Random soak against the model.
        settle();
        for (int it = 0; it < 300; it++) begin
            b = $urandom_range(0, N_BTN - 1);
            pb[b] = ~pb[b];
            ev_ready = ($urandom_range(0, 3) != 0);
            if (it == 150) pulse_reset();
            repeat ($urandom_range(1, 24)) step();
        end
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
